// File: rtl/counter_pkg.sv
// Shared definitions for the Counter_N count bus and its sequence checker.
// Holds the checker FSM encoding and the modulo-increment helper.
// Pure declarations: no logic, no latency, no flow control of its own.
package counter_pkg;

  // Checker FSM encoding, kept as plain constants for legacy tool flows
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // (val + 1) mod n using an explicit compare against n-1, so moduli that are
  // not a power of two wrap correctly instead of relying on bus overflow
  function automatic logic [31:0] next_mod(input logic [31:0] val, input logic [31:0] n);
    if (val == n - 32'd1) begin
      return 32'd0;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/counter_seq_checker.sv
// Monitors a free-running modulo-N count bus: locks on, flags breaks, tallies errors.
// Latency: one cycle, every output is registered and reflects the sample of the previous edge.
// Backpressure: none; samples are taken only when Valid_in=1 and everything holds otherwise.
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int N        = 10,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Count_in,
  input  logic             Valid_in,
  input  logic             Clear_err,
  output logic             Locked,
  output logic             Error,
  output logic             Wrap,
  output logic [WIDTH-1:0] Expected,
  output logic [ERR_W-1:0] Err_count
);

  localparam int               GW        = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_CNT);
  localparam logic [WIDTH:0]   N_V       = (WIDTH + 1)'(N);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [GW-1:0]    good_q,     good_d;
  logic             locked_q,   locked_d;
  logic             error_q,    error_d;
  logic             wrap_q,     wrap_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

  logic             in_range;
  logic             match;
  logic [WIDTH-1:0] seq_next;
  logic [GW-1:0]    good_inc;

  // Sample classification; Expected is always in range, so a match implies in range
  always_comb begin
    in_range = ({1'b0, Count_in} < N_V);
    match    = (Count_in == expected_q);
    seq_next = WIDTH'(next_mod(32'(Count_in), 32'(N)));
    good_inc = good_q + 1'b1;
  end

  // Next-state and datapath decisions, only acted on for valid samples
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    error_d    = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (Valid_in) begin
      case (state_q)
        HUNT: begin
          if (in_range) begin
            expected_d = seq_next;
            good_d     = '0;
            state_d    = ACQ;
          end
        end
        ACQ: begin
          if (match) begin
            expected_d = seq_next;
            good_d     = good_inc;
            if (good_inc == LOCK_LAST) begin
              state_d = LOCKED;
            end
          end else if (in_range) begin
            // Re-seed from this sample and start the run over
            expected_d = seq_next;
            good_d     = '0;
          end else begin
            good_d  = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_d = seq_next;
            // A correct step onto 0 can only follow N-1
            wrap_d     = (Count_in == '0);
          end else begin
            error_d = 1'b1;
            good_d  = '0;
            state_d = HUNT;
          end
        end
        default: begin
          good_d  = '0;
          state_d = HUNT;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the Error pulse is unaffected
    if (Clear_err) begin
      err_cnt_d = '0;
    end else if (error_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= HUNT;
      expected_q <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      wrap_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      wrap_q     <= wrap_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Locked    = locked_q;
  assign Error     = error_q;
  assign Wrap      = wrap_q;
  assign Expected  = expected_q;
  assign Err_count = err_cnt_q;

endmodule
